// File: rtl/idct_8_stage_1_inner_pkg.sv
// Shared types and constants for the 8-point IDCT stage-1 inner butterfly.
// Optional build macro: IDCT_STAGE1_HALVE_EN (halve the butterfly outputs).
package idct_pkg;

  localparam int LANE_W  = 64;
  localparam int N_LANES = 8;
  localparam int N_PAIRS = N_LANES / 2;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = 3;

  // Lane index helpers: pair p uses lane p (sum) and lane LAST_LANE-p (difference)
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(N_LANES - 1);
  localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(N_PAIRS - 1);

  typedef logic [LANE_W-1:0]              lane_t;
  typedef logic [N_LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/idct_8_stage_1_inner_if.sv
// Streaming valid/ready bundle for the IDCT stage-1 inner block.
// slave = block side, master = producer/consumer side.
interface idct_8_stage_1_inner_if;
  import idct_pkg::*;

  vec_t i_data_in;
  logic i_valid;
  logic i_ready;
  vec_t o_data_out;
  logic o_valid;
  logic o_ready;
  logic o_busy;

  modport slave (
    input  i_data_in, i_valid, o_ready,
    output i_ready, o_data_out, o_valid, o_busy
  );

  modport master (
    output i_data_in, i_valid, o_ready,
    input  i_ready, o_data_out, o_valid, o_busy
  );

endinterface

// File: rtl/idct_8_stage_1_inner_bfly_pair.sv
// Combinational inverse butterfly for one lane pair: a = s+d, b = s-d.
// With IDCT_STAGE1_HALVE_EN defined, both results are computed in 65 bits and
// arithmetically shifted right by one (rounds toward -inf, cannot overflow).
// Without it, results wrap modulo 2^64 (gain-2 transposed butterfly).
module idct_bfly_pair
  import idct_pkg::*;
(
  input  lane_t s,
  input  lane_t d,
  output lane_t a,
  output lane_t b
);

`ifdef IDCT_STAGE1_HALVE_EN
  logic signed [LANE_W:0] s_x, d_x, sum, dif;

  assign s_x = {s[LANE_W-1], s};
  assign d_x = {d[LANE_W-1], d};
  assign sum = s_x + d_x;
  assign dif = s_x - d_x;
  // The 65-bit halved value always fits back into 64 bits
  assign a   = LANE_W'(sum >>> 1);
  assign b   = LANE_W'(dif >>> 1);
`else
  assign a = s + d;
  assign b = s - d;
`endif

endmodule

// File: rtl/idct_8_stage_1_inner.sv
// IDCT 8-point stage-1 inner: accepts one vector (sums in lanes 0..3,
// differences in lanes 7..4), reconstructs one lane pair per cycle through a
// single butterfly, then holds the result until the consumer takes it.
// Optional build macro: IDCT_STAGE1_HALVE_EN (see idct_bfly_pair).
module idct_8_stage_1_inner
  import idct_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  idct_8_stage_1_inner_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  vec_t             in_q, in_d;
  vec_t             res_q, res_d;

  logic [IDX_W-1:0] idx_s, idx_d;
  lane_t            s, d, a, b;

  // Current pair: sum lane p, difference lane 7-p
  assign idx_s = {1'b0, cnt_q};
  assign idx_d = LAST_LANE - idx_s;
  assign s     = in_q[idx_s];
  assign d     = in_q[idx_d];

  idct_bfly_pair u_bfly (
    .s (s),
    .d (d),
    .a (a),
    .b (b)
  );

  // Next-state, counter and datapath register updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          in_d    = bus.i_data_in;
          res_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        res_d[idx_s] = a;
        res_d[idx_d] = b;
        // 2-bit counter wraps 3->0 on the same edge that enters HOLD
        cnt_d        = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_PAIR) state_d = HOLD;
      end
      HOLD: begin
        if (bus.o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset discards any vector in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

  // Handshake outputs decode straight from the state register
  assign bus.i_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == HOLD);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_data_out = res_q;

endmodule
